// File: rtl/dac_cmd_sched.sv
// Byte-stream command parser that configures and gates the DAC waveform controller.
// Frames are HDR, CMD, ARG, CHK; reconfiguring while running forces a restart gap.
module dac_cmd_sched #(
    parameter logic [7:0] HDR        = 8'hAA,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 50000
) (
    input  logic       dac_clk_in,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] signal_select,
    output logic [7:0] clk_select,
    output logic       ctl_data_val,
    output logic       busy,
    output logic       err_pulse
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ARG,
        GET_CHK,
        GAP
    } state_t;

    state_t        state_q;
    logic [7:0]    cmd_q;
    logic [7:0]    arg_q;
    logic [7:0]    sig_q;
    logic [7:0]    clk_q;
    logic          cval_q;
    logic          run_q;
    logic          err_q;
    logic [7:0]    gap_q;
    logic [TW-1:0] to_q;

    logic accept;
    logic to_hit;
    logic is_clk;
    logic is_sig;
    logic is_start;
    logic is_stop;
    logic frame_ok;

    assign rx_ready      = (state_q != GAP);
    assign busy          = (state_q != IDLE);
    assign accept        = rx_valid && rx_ready;
    assign to_hit        = (to_q == TW'(TIMEOUT - 1));
    assign signal_select = sig_q;
    assign clk_select    = clk_q;
    assign ctl_data_val  = cval_q;
    assign err_pulse     = err_q;

    // Frame verdict, evaluated on the cycle the checksum byte is accepted.
    always_comb begin
        is_clk   = (cmd_q == 8'h01);
        is_sig   = (cmd_q == 8'h02);
        is_start = (cmd_q == 8'h03);
        is_stop  = (cmd_q == 8'h04);
        frame_ok = (rx_data == (cmd_q ^ arg_q))
                 && ((is_clk && (arg_q inside {[8'h20:8'h24]}))
                  || (is_sig && (arg_q != 8'h00))
                  || is_start
                  || is_stop);
    end

    always_ff @(posedge dac_clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= 8'h00;
            arg_q   <= 8'h00;
            sig_q   <= 8'h01;
            clk_q   <= 8'h20;
            cval_q  <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= 8'h00;
            to_q    <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    to_q <= '0;
                    if (accept && rx_data == HDR) begin
                        state_q <= GET_CMD;
                    end
                end
                GET_CMD, GET_ARG: begin
                    if (accept) begin
                        to_q <= '0;
                        if (state_q == GET_CMD) begin
                            cmd_q   <= rx_data;
                            state_q <= GET_ARG;
                        end else begin
                            arg_q   <= rx_data;
                            state_q <= GET_CHK;
                        end
                    end else if (to_hit) begin
                        to_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                GET_CHK: begin
                    if (accept) begin
                        to_q    <= '0;
                        state_q <= IDLE;
                        if (!frame_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            unique case (1'b1)
                                is_clk, is_sig: begin
                                    if (is_clk) clk_q <= arg_q;
                                    else        sig_q <= arg_q;
                                    // Output must drop before the new setting is seen.
                                    if (run_q) begin
                                        cval_q  <= 1'b0;
                                        gap_q   <= 8'(GAP_CYCLES - 1);
                                        state_q <= GAP;
                                    end
                                end
                                is_start: begin
                                    run_q  <= 1'b1;
                                    cval_q <= 1'b1;
                                end
                                is_stop: begin
                                    run_q  <= 1'b0;
                                    cval_q <= 1'b0;
                                end
                            endcase
                        end
                    end else if (to_hit) begin
                        to_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == 8'h00) begin
                        cval_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 8'h01;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
